rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between the WB stage and a long-latency unit (LLU, e.g. a multi-cycle mul/div).

---
 rtl/rf_wport_arbiter.sv | 88 ++++++++
 tb/tb_rf_wport_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the RF write port between WB (priority) and a long-latency unit with starvation relief.
// Optional RF_WPORT_STAT_EN adds stat_conflict_cnt_o counting cycles both sides requested the port.
module rf_wport_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic [31:0] wb_pc_i,
  output logic        wb_hold_o,
  input  logic        llu_valid_i,
  input  logic [4:0]  llu_waddr_i,
  input  logic [31:0] llu_wdata_i,
  input  logic [31:0] llu_pc_i,
  output logic        llu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] debug_wb_pc_o,
  output logic [3:0]  debug_wb_rf_wen_o,
  output logic [4:0]  debug_wb_rf_wnum_o,
  output logic [31:0] debug_wb_rf_wdata_o
`ifdef RF_WPORT_STAT_EN
  , output logic [31:0] stat_conflict_cnt_o
`endif
);
  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FORCE  = 1'b1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [31:0]      pc_q, pc_d;
  logic             wb_req, wb_grant, llu_grant, wb_nowrite;
  assign wb_req      = wb_valid_i & wb_we_i;
  assign wb_hold_o   = state_q == FORCE;
  assign wb_grant    = ~wb_hold_o & wb_req;
  assign llu_grant   = llu_valid_i & (wb_hold_o | ~wb_req);
  assign llu_ready_o = llu_grant;
  // non-writing WB retire still reports its PC when the LLU does not take the port
  assign wb_nowrite  = wb_valid_i & ~wb_we_i & ~wb_hold_o & ~llu_grant;
  always_comb begin
    wait_d     = (wb_hold_o | llu_grant | ~llu_valid_i) ? '0 : (wait_q == LIMIT) ? wait_q : wait_q + 1'b1;
    state_d    = (~wb_hold_o && wait_d == LIMIT) ? FORCE : NORMAL;
    rf_we_d    = wb_grant ? |wb_waddr_i : llu_grant ? |llu_waddr_i : 1'b0;
    rf_waddr_d = wb_grant ? wb_waddr_i : llu_grant ? llu_waddr_i : rf_waddr_q;
    rf_wdata_d = wb_grant ? wb_wdata_i : llu_grant ? llu_wdata_i : rf_wdata_q;
    pc_d       = (wb_grant | wb_nowrite) ? wb_pc_i : llu_grant ? llu_pc_i : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pc_q       <= pc_d;
    end
  end
  assign rf_we_o             = rf_we_q;
  assign rf_waddr_o          = rf_waddr_q;
  assign rf_wdata_o          = rf_wdata_q;
  assign debug_wb_pc_o       = pc_q;
  assign debug_wb_rf_wen_o   = {4{rf_we_q}};
  assign debug_wb_rf_wnum_o  = rf_waddr_q;
  assign debug_wb_rf_wdata_o = rf_wdata_q;
`ifdef RF_WPORT_STAT_EN
  logic [31:0] stat_q;
  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else if (wb_req & llu_valid_i) stat_q <= stat_q + 32'd1;
  end
  assign stat_conflict_cnt_o = stat_q;
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed stimulus, spec-level model checked every cycle, plus literal spot checks.
module tb_rf_wport_arbiter;
  localparam int LIM = 3;
  logic        clk = 0, reset = 1;
  logic        wb_valid_i = 0, wb_we_i = 0, llu_valid_i = 0;
  logic [4:0]  wb_waddr_i = 0, llu_waddr_i = 0;
  logic [31:0] wb_wdata_i = 0, wb_pc_i = 0, llu_wdata_i = 0, llu_pc_i = 0;
  logic        wb_hold_o, llu_ready_o, rf_we_o;
  logic [4:0]  rf_waddr_o, debug_wb_rf_wnum_o;
  logic [31:0] rf_wdata_o, debug_wb_pc_o, debug_wb_rf_wdata_o;
  logic [3:0]  debug_wb_rf_wen_o;
`ifdef RF_WPORT_STAT_EN
  logic [31:0] stat_conflict_cnt_o;
`endif
  int total = 0, bad = 0;
  bit started = 0;
  int m_wait = 0;
  bit m_force = 0, m_we = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0, m_pc = 0, m_stat = 0;
  rf_wport_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
    .wb_wdata_i(wb_wdata_i), .wb_pc_i(wb_pc_i), .wb_hold_o(wb_hold_o),
    .llu_valid_i(llu_valid_i), .llu_waddr_i(llu_waddr_i), .llu_wdata_i(llu_wdata_i),
    .llu_pc_i(llu_pc_i), .llu_ready_o(llu_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .debug_wb_pc_o(debug_wb_pc_o), .debug_wb_rf_wen_o(debug_wb_rf_wen_o),
    .debug_wb_rf_wnum_o(debug_wb_rf_wnum_o), .debug_wb_rf_wdata_o(debug_wb_rf_wdata_o)
`ifdef RF_WPORT_STAT_EN
    , .stat_conflict_cnt_o(stat_conflict_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  // model: WB wins unless the previous cycle exhausted the LLU's patience
  always @(posedge clk) begin
    bit wreq, wg, lg;
    if (reset) begin
      started = 1; m_wait = 0; m_force = 0; m_we = 0;
      m_addr = 0; m_data = 0; m_pc = 0; m_stat = 0;
    end else begin
      wreq = wb_valid_i && wb_we_i;
      wg = !m_force && wreq;
      lg = llu_valid_i && (m_force || !wreq);
      if (wreq && llu_valid_i) m_stat = m_stat + 1;
      if (wg) begin
        m_we = wb_waddr_i != 0; m_addr = wb_waddr_i; m_data = wb_wdata_i; m_pc = wb_pc_i;
      end else if (lg) begin
        m_we = llu_waddr_i != 0; m_addr = llu_waddr_i; m_data = llu_wdata_i; m_pc = llu_pc_i;
      end else begin
        m_we = 0;
        if (wb_valid_i && !m_force) m_pc = wb_pc_i;
      end
      if (m_force) begin
        m_force = 0; m_wait = 0;
      end else begin
        m_wait = (llu_valid_i && !lg) ? ((m_wait + 1 > LIM) ? LIM : m_wait + 1) : 0;
        m_force = m_wait == LIM;
      end
    end
  end
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("m_hold", wb_hold_o, m_force);
      chk("m_llu_ready", llu_ready_o, llu_valid_i && (m_force || !(wb_valid_i && wb_we_i)));
      chk("m_rf_we", rf_we_o, m_we);
      chk("m_rf_waddr", rf_waddr_o, m_addr);
      chk("m_rf_wdata", rf_wdata_o, m_data);
      chk("m_dbg_pc", debug_wb_pc_o, m_pc);
      chk("m_dbg_wen", debug_wb_rf_wen_o, {4{m_we}});
      chk("m_dbg_wnum", debug_wb_rf_wnum_o, m_addr);
      chk("m_dbg_wdata", debug_wb_rf_wdata_o, m_data);
`ifdef RF_WPORT_STAT_EN
      chk("m_stat", stat_conflict_cnt_o, m_stat);
`endif
    end
  end
  task automatic drv(input logic r, input logic wv, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [31:0] wpc, input logic lv,
                     input logic [4:0] la, input logic [31:0] ld, input logic [31:0] lpc);
    @(posedge clk); #1;
    reset = r; wb_valid_i = wv; wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd; wb_pc_i = wpc;
    llu_valid_i = lv; llu_waddr_i = la; llu_wdata_i = ld; llu_pc_i = lpc;
    @(negedge clk);
  endtask
  task automatic idle(input logic r);
    drv(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic both(input logic r);
    drv(r, 1, 1, 5'd3, 32'h33, 32'h300, 1, 5'd9, 32'h99, 32'h900);
  endtask
  initial begin
    idle(1); idle(1);
    idle(0);
    chk("rst_rf_we", rf_we_o, 0); chk("rst_pc", debug_wb_pc_o, 0); chk("rst_hold", wb_hold_o, 0);
    drv(0, 1, 1, 5'd5, 32'h11, 32'h100, 0, 0, 0, 0);
    chk("wb_hold0", wb_hold_o, 0);
    idle(0);
    chk("wb_we", rf_we_o, 1); chk("wb_addr", rf_waddr_o, 5); chk("wb_data", rf_wdata_o, 32'h11);
    chk("wb_wen", debug_wb_rf_wen_o, 4'hF); chk("wb_pc", debug_wb_pc_o, 32'h100);
    drv(0, 1, 0, 0, 0, 32'h104, 1, 5'd7, 32'hAB, 32'h200);
    chk("llu_ready", llu_ready_o, 1);
    drv(0, 1, 0, 0, 0, 32'h108, 0, 0, 0, 0);
    chk("llu_addr", rf_waddr_o, 7); chk("llu_data", rf_wdata_o, 32'hAB);
    chk("llu_pc", debug_wb_pc_o, 32'h200); chk("llu_we", rf_we_o, 1);
    idle(0);
    chk("nw_we", rf_we_o, 0); chk("nw_pc", debug_wb_pc_o, 32'h108); chk("nw_addr", rf_waddr_o, 7);
    for (int i = 0; i < LIM; i++) begin
      both(0);
      chk("starve_hold", wb_hold_o, 0); chk("starve_lrdy", llu_ready_o, 0);
    end
    both(0);
    chk("force_hold", wb_hold_o, 1); chk("force_lrdy", llu_ready_o, 1);
    both(0);
    chk("after_hold", wb_hold_o, 0); chk("after_lrdy", llu_ready_o, 0);
    chk("force_addr", rf_waddr_o, 9); chk("force_data", rf_wdata_o, 32'h99);
    idle(0);
    chk("resume_addr", rf_waddr_o, 3);
    drv(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h55, 32'h400);
    chk("r0_lrdy", llu_ready_o, 1);
    idle(0);
    chk("r0_we", rf_we_o, 0); chk("r0_wnum", debug_wb_rf_wnum_o, 0);
    for (int i = 0; i < LIM; i++) both(0);
    both(1);
    chk("rstf_hold", wb_hold_o, 1);
    both(0);
    chk("post_rst_hold", wb_hold_o, 0); chk("post_rst_we", rf_we_o, 0);
    both(0); chk("post_rst_h2", wb_hold_o, 0);
    both(0); chk("post_rst_h3", wb_hold_o, 0);
    both(0); chk("post_rst_h4", wb_hold_o, 1);
`ifdef RF_WPORT_STAT_EN
    idle(1);
    for (int i = 0; i < 5; i++) both(0);
    idle(0);
    chk("stat5", stat_conflict_cnt_o, 5);
`endif
    idle(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
